// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises the active-low key pin, debounces it with a
// consecutive-sample counter and emits press / release / long-press strobes.
module key_debounce #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned LONG_CYCLES     = 0,
    parameter int unsigned CNT_W           = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic key,
    output logic key_out,
    output logic press,
    // "release" is a reserved word, so the release strobe is named key_release.
    output logic key_release,
    output logic long_press
);

    typedef enum logic [1:0] {
        IDLE_HIGH,
        WAIT_LOW,
        HELD_LOW,
        WAIT_HIGH
    } state_t;

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_C    = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       hold_q, hold_d;
    logic                   key_out_d, press_d, release_d, long_d;

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '1;
            state_q     <= IDLE_HIGH;
            cnt_q       <= '0;
            hold_q      <= '0;
            key_out     <= 1'b1;
            press       <= 1'b0;
            key_release <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], key};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            key_out     <= key_out_d;
            press       <= press_d;
            key_release <= release_d;
            long_press  <= long_d;
        end
    end

    // cnt holds the number of consecutive differing samples already seen, so the
    // DEBOUNCE_CYCLES-th sample is accepted on the same edge it is observed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hold_d    = hold_q;
        key_out_d = key_out;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;

        if (!key_out && LONG_CYCLES != 0 && hold_q != LONG_C) begin
            hold_d = hold_q + 1'b1;
            long_d = (hold_q == LONG_LAST);
        end

        unique case (state_q)
            IDLE_HIGH: begin
                cnt_d = '0;
                if (!s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = HELD_LOW;
                        key_out_d = 1'b0;
                        press_d   = 1'b1;
                        hold_d    = '0;
                    end else begin
                        state_d = WAIT_LOW;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (s) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = HELD_LOW;
                    key_out_d = 1'b0;
                    press_d   = 1'b1;
                    cnt_d     = '0;
                    hold_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HELD_LOW: begin
                cnt_d = '0;
                if (s) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_d   = IDLE_HIGH;
                        key_out_d = 1'b1;
                        release_d = 1'b1;
                        hold_d    = '0;
                        long_d    = 1'b0;
                    end else begin
                        state_d = WAIT_HIGH;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!s) begin
                    state_d = HELD_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = IDLE_HIGH;
                    key_out_d = 1'b1;
                    release_d = 1'b1;
                    cnt_d     = '0;
                    hold_d    = '0;
                    long_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = IDLE_HIGH;
                cnt_d     = '0;
                hold_d    = '0;
                key_out_d = 1'b1;
                long_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed scenarios plus random key activity, compared
// each cycle against a sliding-window reference model.
module tb_key_debounce;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic clk = 1'b0;
    logic rst;
    logic key;
    logic key_out, press, key_release, long_press;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    key_debounce #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .LONG_CYCLES    (LONG),
        .CNT_W          (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key        (key),
        .key_out    (key_out),
        .press      (press),
        .key_release(key_release),
        .long_press (long_press)
    );

    // Reference: a delay line for the pin, and a window of the last DEB delayed
    // samples; the level flips when the whole window disagrees with it.
    bit chain [SYNC];
    bit hist  [DEB];
    bit m_out, m_press, m_rel, m_long;
    int edge_n, press_edge;

    task automatic model_edge(input bit r, input bit k);
        bit smp;
        bit uniform;
        m_press = 1'b0;
        m_rel   = 1'b0;
        m_long  = 1'b0;
        if (r) begin
            foreach (chain[i]) chain[i] = 1'b1;
            foreach (hist[i]) hist[i] = 1'b1;
            m_out      = 1'b1;
            edge_n     = 0;
            press_edge = 0;
            return;
        end
        edge_n++;
        smp = chain[SYNC-1];
        for (int i = SYNC - 1; i > 0; i--) chain[i] = chain[i-1];
        chain[0] = k;
        for (int i = DEB - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = smp;
        uniform = 1'b1;
        foreach (hist[i]) if (hist[i] != smp) uniform = 1'b0;
        if (uniform && smp != m_out) begin
            m_out = smp;
            if (!smp) begin
                m_press    = 1'b1;
                press_edge = edge_n;
            end else begin
                m_rel = 1'b1;
            end
        end else if (!m_out && (edge_n - press_edge) == LONG) begin
            m_long = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit k);
        rst = r;
        key = k;
        @(posedge clk);
        model_edge(r, k);
        @(negedge clk);
        check("key_out", key_out, m_out);
        check("press", press, m_press);
        check("release", key_release, m_rel);
        check("long_press", long_press, m_long);
    endtask

    initial begin
        int  cnt_p, cnt_r, cnt_l;
        int  run;
        bit  kv;
        bit  rr;

        // Reset with key held low, then boot-time press after SYNC+DEB edges.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            check("rst_key_out", key_out, 1'b1);
            check("rst_press", press, 1'b0);
        end
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b0, 1'b0);
            check("boot_press", press, (i == 6) ? 1'b1 : 1'b0);
            check("boot_key_out", key_out, (i >= 6) ? 1'b0 : 1'b1);
        end
        repeat (12) cycle(1'b0, 1'b1);

        // Clean press held 20 cycles, then clean release.
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b0);
            if (i == 5) check("clean_pre", key_out, 1'b1);
            if (i == 6) check("clean_press", press, 1'b1);
            if (i == 7) check("clean_press_once", press, 1'b0);
            if (i == 16) check("clean_long", long_press, 1'b1);
        end
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b0, 1'b1);
            if (i == 5) check("clean_rel_pre", key_out, 1'b0);
            if (i == 6) check("clean_release", key_release, 1'b1);
            if (i == 7) check("clean_rel_once", key_release, 1'b0);
        end

        // Press-side bounce: no strobes, then a real press.
        cnt_p = 0;
        cnt_r = 0;
        repeat (3) begin cycle(1'b0, 1'b0); cnt_p += int'(press); end
        cycle(1'b0, 1'b1); cnt_p += int'(press);
        repeat (3) begin cycle(1'b0, 1'b0); cnt_p += int'(press); end
        repeat (8) begin cycle(1'b0, 1'b1); cnt_p += int'(press); cnt_r += int'(key_release); end
        check("bounce_no_press", cnt_p, 0);
        check("bounce_no_release", cnt_r, 0);
        check("bounce_level", key_out, 1'b1);
        cnt_p = 0;
        repeat (10) begin cycle(1'b0, 1'b0); cnt_p += int'(press); end
        check("bounce_one_press", cnt_p, 1);

        // Release-side bounce during the same hold; long press still fires once.
        cnt_r = 0;
        cnt_l = 0;
        repeat (3) begin cycle(1'b0, 1'b1); cnt_r += int'(key_release); cnt_l += int'(long_press); end
        repeat (10) begin cycle(1'b0, 1'b0); cnt_r += int'(key_release); cnt_l += int'(long_press); end
        check("relbounce_no_release", cnt_r, 0);
        check("relbounce_level", key_out, 1'b0);
        check("relbounce_long_once", cnt_l, 1);
        repeat (12) begin cycle(1'b0, 1'b1); cnt_l += int'(long_press); end
        check("long_no_repeat", cnt_l, 1);
        check("relbounce_released", key_out, 1'b1);

        // Short press: 8 cycles held, no long press.
        cnt_p = 0;
        cnt_l = 0;
        repeat (8) begin cycle(1'b0, 1'b0); cnt_p += int'(press); cnt_l += int'(long_press); end
        repeat (12) begin cycle(1'b0, 1'b1); cnt_p += int'(press); cnt_l += int'(long_press); end
        check("short_press", cnt_p, 1);
        check("short_no_long", cnt_l, 0);

        // Reset mid-count restarts the debounce.
        repeat (5) cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("midrst_press", press, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            cycle(1'b0, 1'b0);
            check("midrst_timing", press, (i == 6) ? 1'b1 : 1'b0);
        end
        repeat (12) cycle(1'b0, 1'b1);

        // Random bouncing key with occasional resets.
        kv  = 1'b1;
        run = 0;
        for (int i = 0; i < 4000; i++) begin
            if (run == 0) begin
                kv  = ~kv;
                run = $urandom_range(1, 16);
            end
            run--;
            rr = ($urandom_range(0, 299) == 0);
            cycle(rr, kv);
            check("strobe_exclusive", press & key_release, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
